idex_pipe_reg: RTL and testbench

- Parametrised ID/EX pipeline register with a valid/ready handshake, a one-entry skid buffer, synchronous flush (bubble insertion) and a saturating stall counter.
- Sits between decode and execute.
- Carries WB/M/EX control groups, PC+4, both register-file read values, the sign-extended immediate and the rt/rd specifiers as separate output buses.
- Lets execute back-pressure decode without losing a decoded instruction.

---
 rtl/idex_pipe_reg.sv | 139 +++++++++++++
 tb/tb_idex_pipe_reg.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register: valid/ready handshake backed by a one-entry skid buffer,
// synchronous flush that leaves a zero (NOP) bubble, and a saturating stall counter.
module idex_pipe_reg #(
   parameter int XLEN  = 32,
   parameter int RAW   = 5,
   parameter int WB_W  = 2,
   parameter int M_W   = 3,
   parameter int EX_W  = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WB_W-1:0]  wb,
   input  logic [M_W-1:0]   m,
   input  logic [EX_W-1:0]  ex,
   input  logic [XLEN-1:0]  add4,
   input  logic [XLEN-1:0]  readData1,
   input  logic [XLEN-1:0]  readData2,
   input  logic [XLEN-1:0]  signExt,
   input  logic [RAW-1:0]   rt,
   input  logic [RAW-1:0]   rd,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WB_W-1:0]  wb_o,
   output logic [M_W-1:0]   m_o,
   output logic [EX_W-1:0]  ex_o,
   output logic [XLEN-1:0]  add4_o,
   output logic [XLEN-1:0]  rd1_o,
   output logic [XLEN-1:0]  rd2_o,
   output logic [XLEN-1:0]  imm_o,
   output logic [RAW-1:0]   rt_o,
   output logic [RAW-1:0]   rd_o,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int PW = WB_W + M_W + EX_W + 4*XLEN + 2*RAW;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } stateType;

   stateType         state;
   stateType         nextState;
   logic [PW-1:0]    inPay;
   logic [PW-1:0]    mainPay;
   logic [PW-1:0]    skidPay;
   logic [CNT_W-1:0] stallCnt;
   logic             mainValid;
   logic             skidValid;
   logic             accept;
   logic             pop;
   logic             loadMainIn;
   logic             loadMainSkid;
   logic             loadSkid;

   assign inPay = {wb, m, ex, add4, readData1, readData2, signExt, rt, rd};

   // Valid bits are a pure function of the state, so the illegal main=0/skid=1 combination cannot exist.
   assign mainValid = (state != EMPTY);
   assign skidValid = (state == FULL);

   assign in_ready  = !skidValid && !flush && !rst;
   assign out_valid = mainValid;
   assign accept    = in_valid && in_ready;
   assign pop       = mainValid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      if (flush) begin
         nextState = EMPTY;
      end else begin
         unique case (state)
            EMPTY: if (accept) nextState = ONE;
            ONE: begin
               if (accept && !pop)      nextState = FULL;
               else if (!accept && pop) nextState = EMPTY;
            end
            FULL:    if (pop) nextState = ONE;
            default: nextState = EMPTY;
         endcase
      end
   end

   // Accept already implies no flush; the FULL refill path must still be gated explicitly.
   always_comb begin
      loadMainIn   = 1'b0;
      loadMainSkid = 1'b0;
      loadSkid     = 1'b0;
      if (!flush) begin
         loadMainIn   = accept && ((state == EMPTY) || ((state == ONE) && pop));
         loadSkid     = accept && (state == ONE) && !pop;
         loadMainSkid = (state == FULL) && pop;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mainPay <= '0;
         skidPay <= '0;
      end else if (flush) begin
         mainPay <= '0;
         skidPay <= '0;
      end else begin
         if (loadMainIn) begin
            mainPay <= inPay;
         end else if (loadMainSkid) begin
            mainPay <= skidPay;
         end
         if (loadSkid) begin
            skidPay <= inPay;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stallCnt <= '0;
      end else if (mainValid && !out_ready && !flush && (stallCnt != {CNT_W{1'b1}})) begin
         stallCnt <= stallCnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign {wb_o, m_o, ex_o, add4_o, rd1_o, rd2_o, imm_o, rt_o, rd_o} = mainPay;
   assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Bench for idex_pipe_reg: a two-deep FIFO model checked every cycle, plus directed
// literal checks for streaming, back-pressure, flush, async reset and a wide/saturating instance.
module tb_idex_pipe_reg;

   localparam int PW = 2 + 3 + 4 + 4*32 + 2*5;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush, in_valid, in_ready, out_valid, out_ready;
   logic [1:0]  wb, wb_o;
   logic [2:0]  m, m_o;
   logic [3:0]  ex, ex_o;
   logic [31:0] add4, readData1, readData2, signExt;
   logic [31:0] add4_o, rd1_o, rd2_o, imm_o;
   logic [4:0]  rt, rd, rt_o, rd_o;
   logic [15:0] stall_cnt;

   logic        flushB, inValidB, inReadyB, outValidB, outReadyB;
   logic [1:0]  wbB, wbOB;
   logic [2:0]  mB, mOB;
   logic [3:0]  exB, exOB;
   logic [63:0] add4B, rd1B, rd2B, immB, add4OB, rd1OB, rd2OB, immOB;
   logic [5:0]  rtB, rdB, rtOB, rdOB;
   logic [3:0]  stallCntB;

   int checks   = 0;
   int failures = 0;

   logic [PW-1:0] benchIn, benchOut;
   logic [PW-1:0] mq[$];
   bit            zeroOut;
   int            mcnt;

   assign benchIn  = {wb, m, ex, add4, readData1, readData2, signExt, rt, rd};
   assign benchOut = {wb_o, m_o, ex_o, add4_o, rd1_o, rd2_o, imm_o, rt_o, rd_o};

   always #5 clk = ~clk;

   idex_pipe_reg dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .wb(wb), .m(m), .ex(ex), .add4(add4), .readData1(readData1), .readData2(readData2),
      .signExt(signExt), .rt(rt), .rd(rd), .out_valid(out_valid), .out_ready(out_ready),
      .wb_o(wb_o), .m_o(m_o), .ex_o(ex_o), .add4_o(add4_o), .rd1_o(rd1_o), .rd2_o(rd2_o),
      .imm_o(imm_o), .rt_o(rt_o), .rd_o(rd_o), .stall_cnt(stall_cnt)
   );

   idex_pipe_reg #(.XLEN(64), .RAW(6), .CNT_W(4)) dutWide (
      .clk(clk), .rst(rst), .flush(flushB), .in_valid(inValidB), .in_ready(inReadyB),
      .wb(wbB), .m(mB), .ex(exB), .add4(add4B), .readData1(rd1B), .readData2(rd2B),
      .signExt(immB), .rt(rtB), .rd(rdB), .out_valid(outValidB), .out_ready(outReadyB),
      .wb_o(wbOB), .m_o(mOB), .ex_o(exOB), .add4_o(add4OB), .rd1_o(rd1OB), .rd2_o(rd2OB),
      .imm_o(immOB), .rt_o(rtOB), .rd_o(rdOB), .stall_cnt(stallCntB)
   );

   task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Payload fields are derived from add4 so every instruction is distinguishable end to end.
   task automatic applyStimulus(input logic v, input logic r, input logic f, input logic [31:0] a);
      in_valid  = v;
      out_ready = r;
      flush     = f;
      add4      = a;
      readData1 = a ^ 32'h1111_0000;
      readData2 = ~a;
      signExt   = {a[15:0], a[15:0]};
      wb        = a[3:2];
      m         = a[4:2];
      ex        = a[5:2];
      rt        = a[6:2];
      rd        = a[7:3];
      tick();
   endtask

   // Reference model: a FIFO of capacity two; flush empties it, pop and accept use pre-edge occupancy.
   always @(posedge clk or posedge rst) begin : model
      bit canTake;
      if (rst) begin
         mq.delete();
         zeroOut = 1'b1;
         mcnt    = 0;
      end else begin
         canTake = (mq.size() < 2) && !flush;
         if ((mq.size() > 0) && !out_ready && !flush && (mcnt < 65535)) mcnt++;
         if (flush) begin
            mq.delete();
            zeroOut = 1'b1;
         end else begin
            if ((mq.size() > 0) && out_ready) begin
               void'(mq.pop_front());
               zeroOut = 1'b0;
            end
            if (in_valid && canTake) mq.push_back(benchIn);
         end
      end
   end

   always @(negedge clk) begin
      checkOutput("in_ready", 256'(in_ready), 256'(!rst && !flush && (mq.size() < 2)));
      checkOutput("out_valid", 256'(out_valid), 256'(mq.size() > 0));
      checkOutput("stall_cnt", 256'(stall_cnt), 256'(mcnt));
      if (mq.size() > 0)  checkOutput("payload", 256'(benchOut), 256'(mq[0]));
      else if (zeroOut)   checkOutput("bubble", 256'(benchOut), 256'(0));
   end

   initial begin
      rst = 1'b1;
      {flush, in_valid, out_ready, wb, m, ex, add4, readData1, readData2, signExt, rt, rd} = '0;
      {flushB, inValidB, outReadyB, wbB, mB, exB, add4B, rd1B, rd2B, immB, rtB, rdB} = '0;
      repeat (2) tick();
      checkOutput("reset_in_ready", 256'(in_ready), 256'(0));
      checkOutput("reset_out_valid", 256'(out_valid), 256'(0));
      checkOutput("reset_add4_o", 256'(add4_o), 256'(0));
      rst = 1'b0;
      #1;
      checkOutput("release_in_ready", 256'(in_ready), 256'(1));
      tick();

      $display("[TB] streaming");
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 32'(4*i));
         checkOutput("stream_add4", 256'(add4_o), 256'(4*i));
         checkOutput("stream_valid", 256'(out_valid), 256'(1));
         checkOutput("stream_in_ready", 256'(in_ready), 256'(1));
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("stream_drained", 256'(out_valid), 256'(0));
      checkOutput("stream_stall", 256'(stall_cnt), 256'(0));

      $display("[TB] back-pressure");
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h100);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h104);
      checkOutput("bp_full_in_ready", 256'(in_ready), 256'(0));
      checkOutput("bp_head_a", 256'(add4_o), 256'h100);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h108);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h108);
      checkOutput("bp_stall_cnt", 256'(stall_cnt), 256'(3));
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h108);
      checkOutput("bp_head_b", 256'(add4_o), 256'h104);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h108);
      checkOutput("bp_head_c", 256'(add4_o), 256'h108);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("bp_drained", 256'(out_valid), 256'(0));
      checkOutput("bp_stall_final", 256'(stall_cnt), 256'(3));

      $display("[TB] flush in FULL");
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h200);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h204);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h208);
      in_valid = 1'b0;
      flush    = 1'b0;
      #1;
      checkOutput("flush_out_valid", 256'(out_valid), 256'(0));
      checkOutput("flush_ctrl", 256'({wb_o, m_o, ex_o}), 256'(0));
      checkOutput("flush_in_ready", 256'(in_ready), 256'(1));
      checkOutput("flush_stall_kept", 256'(stall_cnt), 256'(4));
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h20C);
      checkOutput("post_flush_add4", 256'(add4_o), 256'h20C);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);

      $display("[TB] async reset mid-FULL");
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h300);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h304);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("arst_out_valid", 256'(out_valid), 256'(0));
      checkOutput("arst_payload", 256'(benchOut), 256'(0));
      checkOutput("arst_stall_cnt", 256'(stall_cnt), 256'(0));
      checkOutput("arst_in_ready", 256'(in_ready), 256'(0));
      in_valid = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      checkOutput("arst_release_ready", 256'(in_ready), 256'(1));
      checkOutput("arst_release_valid", 256'(out_valid), 256'(0));

      $display("[TB] wide instance and saturation");
      inValidB = 1'b1;
      rd1B     = 64'hFFFF_FFFF_0000_0001;
      rtB      = 6'h3F;
      tick();
      inValidB = 1'b0;
      checkOutput("wide_valid", 256'(outValidB), 256'(1));
      checkOutput("wide_rd1", 256'(rd1OB), 256'h0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_FFFF_FFFF_0000_0001);
      checkOutput("wide_rt", 256'(rtOB), 256'h3F);
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 14) checkOutput("sat_mid", 256'(stallCntB), 256'(14));
      end
      checkOutput("sat_final", 256'(stallCntB), 256'(15));
      checkOutput("sat_rd1_held", 256'(rd1OB), 256'(64'hFFFF_FFFF_0000_0001));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
